// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RISC-V core control path.
package riscv_pkg;

  localparam int PROGRAM_COUNTER_WIDTH = 16;
  localparam int DEFAULT_WAIT_LIMIT    = 255;

  typedef enum logic [2:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_FETCH     = 3'd1,
    SEQ_DECODE    = 3'd2,
    SEQ_EXECUTE   = 3'd3,
    SEQ_MEM       = 3'd4,
    SEQ_WRITEBACK = 3'd5,
    SEQ_HALT      = 3'd6,
    SEQ_FAULT     = 3'd7
  } seq_state_t;

endpackage

// File: rtl/core_sequencer_wait_timer.sv
// Clear/enable wait counter shared by instruction fetch and data access.
// 'expired' is high on the last allowed waiting cycle (count == LIMIT-1),
// so a ready arriving in that same cycle is still accepted by the sequencer.
module wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] MAX_COUNT  = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count_reg;

  // Count waiting cycles; saturate at LIMIT so the counter can never wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != MAX_COUNT)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg >= LAST_COUNT);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE -> [MEM] ->
// WRITEBACK, with HALT and a sticky FAULT state. All outputs are decoded
// combinationally from the registered state and the current-cycle inputs.
module core_sequencer
  import riscv_pkg::*;
#(
  parameter int PROGRAM_COUNTER_WIDTH = riscv_pkg::PROGRAM_COUNTER_WIDTH,
  parameter int WAIT_LIMIT            = DEFAULT_WAIT_LIMIT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             halt_req,
  input  logic [PROGRAM_COUNTER_WIDTH-1:0] pc,
  output logic                             imem_req,
  input  logic                             imem_ready,
  output logic                             ir_load,
  input  logic                             dec_illegal,
  input  logic                             dec_halt,
  input  logic                             dec_mem,
  input  logic                             dec_writes_rd,
  input  logic                             branch_taken,
  output logic                             dmem_req,
  input  logic                             dmem_ready,
  output logic                             rf_we,
  output logic                             pc_run,
  output logic                             pc_jump,
  output logic [2:0]                       state,
  output logic                             busy,
  output logic                             halted,
  output logic                             fault,
  output logic [PROGRAM_COUNTER_WIDTH-1:0] fault_pc
);

  seq_state_t                       state_reg;
  seq_state_t                       state_next;
  logic [PROGRAM_COUNTER_WIDTH-1:0] fault_pc_reg;
  logic                             timer_clr;
  logic                             timer_en;
  logic                             timer_expired;

  // One timer serves both wait states; they are never active together.
  wait_timer #(
    .LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(timer_expired)
  );

  assign timer_clr = ((state_next == SEQ_FETCH) && (state_reg != SEQ_FETCH)) ||
                     ((state_next == SEQ_MEM)   && (state_reg != SEQ_MEM));
  assign timer_en  = ((state_reg == SEQ_FETCH) && !imem_ready) ||
                     ((state_reg == SEQ_MEM)   && !dmem_ready);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= SEQ_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the PC of the instruction that faulted; held until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_pc_reg <= '0;
    end else if ((state_next == SEQ_FAULT) && (state_reg != SEQ_FAULT)) begin
      fault_pc_reg <= pc;
    end
  end

  // Next-state and per-state output decode.
  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dmem_req   = 1'b0;
    rf_we      = 1'b0;
    pc_run     = 1'b0;
    pc_jump    = 1'b0;
    case (state_reg)
      SEQ_IDLE: begin
        if (start) state_next = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load    = 1'b1;
          state_next = SEQ_DECODE;
        end else if (timer_expired) begin
          state_next = SEQ_FAULT;
        end
      end
      SEQ_DECODE: begin
        // Illegal beats halt: a bad opcode must never look like a clean stop.
        if (dec_illegal)   state_next = SEQ_FAULT;
        else if (dec_halt) state_next = SEQ_HALT;
        else               state_next = SEQ_EXECUTE;
      end
      SEQ_EXECUTE: begin
        state_next = dec_mem ? SEQ_MEM : SEQ_WRITEBACK;
      end
      SEQ_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready)         state_next = SEQ_WRITEBACK;
        else if (timer_expired) state_next = SEQ_FAULT;
      end
      SEQ_WRITEBACK: begin
        rf_we      = dec_writes_rd;
        pc_run     = 1'b1;
        pc_jump    = branch_taken;
        state_next = halt_req ? SEQ_HALT : SEQ_FETCH;
      end
      SEQ_HALT: begin
        if (start) state_next = SEQ_FETCH;
      end
      SEQ_FAULT: begin
        state_next = SEQ_FAULT;
      end
      default: begin
        state_next = SEQ_FAULT;
      end
    endcase
  end

  assign state    = state_reg;
  assign busy     = (state_reg == SEQ_FETCH)   || (state_reg == SEQ_DECODE) ||
                    (state_reg == SEQ_EXECUTE) || (state_reg == SEQ_MEM)    ||
                    (state_reg == SEQ_WRITEBACK);
  assign halted   = (state_reg == SEQ_HALT);
  assign fault    = (state_reg == SEQ_FAULT);
  assign fault_pc = fault_pc_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer. The stimulus process pushes the expected
// output vector for every cycle it drives; a monitor on the falling edge pops
// and compares against the DUT outputs.
module tb_core_sequencer;

  localparam int PCW = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start, halt_req;
  logic [PCW-1:0] pc;
  logic           imem_req, imem_ready, ir_load;
  logic           dec_illegal, dec_halt, dec_mem, dec_writes_rd, branch_taken;
  logic           dmem_req, dmem_ready, rf_we, pc_run, pc_jump;
  logic [2:0]     state;
  logic           busy, halted, fault;
  logic [PCW-1:0] fault_pc;

  int n_compared   = 0;
  int n_mismatched = 0;
  bit stim_done    = 1'b0;

  logic [27:0] exp_q[$];
  string       tag_q[$];

  core_sequencer #(
    .PROGRAM_COUNTER_WIDTH(PCW),
    .WAIT_LIMIT           (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .halt_req     (halt_req),
    .pc           (pc),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .ir_load      (ir_load),
    .dec_illegal  (dec_illegal),
    .dec_halt     (dec_halt),
    .dec_mem      (dec_mem),
    .dec_writes_rd(dec_writes_rd),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .rf_we        (rf_we),
    .pc_run       (pc_run),
    .pc_jump      (pc_jump),
    .state        (state),
    .busy         (busy),
    .halted       (halted),
    .fault        (fault),
    .fault_pc     (fault_pc)
  );

  always #5 clk = ~clk;

  // Push the expected outputs for the current cycle, then advance one clock.
  task automatic tick(input string tag, input logic [2:0] st,
                      input logic im, input logic il, input logic dm,
                      input logic we, input logic run, input logic jmp,
                      input logic [PCW-1:0] fpc);
    logic b, h, f;
    b = (st >= 3'd1) && (st <= 3'd5);
    h = (st == 3'd6);
    f = (st == 3'd7);
    exp_q.push_back({st, im, il, dm, we, run, jmp, b, h, f, fpc});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expected cycle record against the live outputs.
  initial begin
    logic [27:0] act, expv;
    string       tag;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        tag  = tag_q.pop_front();
        act  = {state, imem_req, ir_load, dmem_req, rf_we, pc_run, pc_jump,
                busy, halted, fault, fault_pc};
        n_compared++;
        if (act !== expv) begin
          n_mismatched++;
          $display("FAIL %s: actual st=%0d im/il/dm/we/run/jmp/busy/halt/flt=%b fpc=%h required st=%0d flags=%b fpc=%h",
                   tag, act[27:25], act[24:16], act[15:0],
                   expv[27:25], expv[24:16], expv[15:0]);
        end else begin
          $display("ok   %s: st=%0d flags=%b fpc=%h", tag, act[27:25], act[24:16], act[15:0]);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; pc = 16'h0040;
    imem_ready = 1'b0; dmem_ready = 1'b0; dec_illegal = 1'b0; dec_halt = 1'b0;
    dec_mem = 1'b0; dec_writes_rd = 1'b0; branch_taken = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tick("reset",         3'd0, 0,0,0,0,0,0, 16'h0000);
    rst_n = 1'b1;
    tick("idle",          3'd0, 0,0,0,0,0,0, 16'h0000);
    start = 1'b1;
    tick("idle_start",    3'd0, 0,0,0,0,0,0, 16'h0000);
    start = 1'b0;

    // ALU instruction: 1,2,3,5 then back to FETCH.
    imem_ready = 1'b1; dec_writes_rd = 1'b1;
    tick("alu_fetch",     3'd1, 1,1,0,0,0,0, 16'h0000);
    imem_ready = 1'b0;
    tick("alu_decode",    3'd2, 0,0,0,0,0,0, 16'h0000);
    tick("alu_execute",   3'd3, 0,0,0,0,0,0, 16'h0000);
    tick("alu_wb",        3'd5, 0,0,0,1,1,0, 16'h0000);

    // Taken branch; start while busy is ignored.
    imem_ready = 1'b1; dec_writes_rd = 1'b0; branch_taken = 1'b1;
    tick("br_fetch",      3'd1, 1,1,0,0,0,0, 16'h0000);
    imem_ready = 1'b0; start = 1'b1;
    tick("br_decode",     3'd2, 0,0,0,0,0,0, 16'h0000);
    start = 1'b0;
    tick("br_execute",    3'd3, 0,0,0,0,0,0, 16'h0000);
    tick("br_wb",         3'd5, 0,0,0,0,1,1, 16'h0000);
    branch_taken = 1'b0;

    // Load; dmem_ready on the 4th MEM cycle (count == WAIT_LIMIT-1): 8 cycles.
    imem_ready = 1'b1; dec_mem = 1'b1; dec_writes_rd = 1'b1;
    tick("ld_fetch",      3'd1, 1,1,0,0,0,0, 16'h0000);
    imem_ready = 1'b0;
    tick("ld_decode",     3'd2, 0,0,0,0,0,0, 16'h0000);
    tick("ld_execute",    3'd3, 0,0,0,0,0,0, 16'h0000);
    for (int i = 0; i < 3; i++)
      tick($sformatf("ld_mem_wait%0d", i), 3'd4, 0,0,1,0,0,0, 16'h0000);
    dmem_ready = 1'b1;
    tick("ld_mem_ready",  3'd4, 0,0,1,0,0,0, 16'h0000);
    dmem_ready = 1'b0;
    tick("ld_wb",         3'd5, 0,0,0,1,1,0, 16'h0000);
    dec_mem = 1'b0; dec_writes_rd = 1'b0;

    // dec_halt: HALT without a pc_run pulse, then start resumes.
    imem_ready = 1'b1;
    tick("dh_fetch",      3'd1, 1,1,0,0,0,0, 16'h0000);
    imem_ready = 1'b0; dec_halt = 1'b1;
    tick("dh_decode",     3'd2, 0,0,0,0,0,0, 16'h0000);
    dec_halt = 1'b0;
    tick("dh_halt0",      3'd6, 0,0,0,0,0,0, 16'h0000);
    tick("dh_halt1",      3'd6, 0,0,0,0,0,0, 16'h0000);
    start = 1'b1;
    tick("dh_halt_start", 3'd6, 0,0,0,0,0,0, 16'h0000);
    start = 1'b0;

    // halt_req held through an ALU instruction; start in WB loses to halt.
    imem_ready = 1'b1; halt_req = 1'b1; dec_writes_rd = 1'b1;
    tick("hr_fetch",      3'd1, 1,1,0,0,0,0, 16'h0000);
    imem_ready = 1'b0;
    tick("hr_decode",     3'd2, 0,0,0,0,0,0, 16'h0000);
    tick("hr_execute",    3'd3, 0,0,0,0,0,0, 16'h0000);
    start = 1'b1;
    tick("hr_wb",         3'd5, 0,0,0,1,1,0, 16'h0000);
    start = 1'b0; halt_req = 1'b0; dec_writes_rd = 1'b0;
    tick("hr_halt",       3'd6, 0,0,0,0,0,0, 16'h0000);
    start = 1'b1;
    tick("hr_halt_start", 3'd6, 0,0,0,0,0,0, 16'h0000);
    start = 1'b0;

    // Fetch ready on the last allowed waiting cycle is accepted.
    for (int i = 0; i < 3; i++)
      tick($sformatf("lf_wait%0d", i), 3'd1, 1,0,0,0,0,0, 16'h0000);
    imem_ready = 1'b1;
    tick("lf_ready",      3'd1, 1,1,0,0,0,0, 16'h0000);
    imem_ready = 1'b0;
    tick("lf_decode",     3'd2, 0,0,0,0,0,0, 16'h0000);
    tick("lf_execute",    3'd3, 0,0,0,0,0,0, 16'h0000);
    tick("lf_wb",         3'd5, 0,0,0,0,1,0, 16'h0000);

    // Reset asserted while dmem_req is high.
    imem_ready = 1'b1; dec_mem = 1'b1;
    tick("rm_fetch",      3'd1, 1,1,0,0,0,0, 16'h0000);
    imem_ready = 1'b0;
    tick("rm_decode",     3'd2, 0,0,0,0,0,0, 16'h0000);
    tick("rm_execute",    3'd3, 0,0,0,0,0,0, 16'h0000);
    tick("rm_mem",        3'd4, 0,0,1,0,0,0, 16'h0000);
    rst_n = 1'b0;
    tick("rm_mem_rst",    3'd4, 0,0,1,0,0,0, 16'h0000);
    rst_n = 1'b1; dec_mem = 1'b0;
    tick("rm_after_rst",  3'd0, 0,0,0,0,0,0, 16'h0000);

    // Illegal and halt together: illegal wins, fault_pc captured in DECODE.
    start = 1'b1;
    tick("il_start",      3'd0, 0,0,0,0,0,0, 16'h0000);
    start = 1'b0; imem_ready = 1'b1;
    tick("il_fetch",      3'd1, 1,1,0,0,0,0, 16'h0000);
    imem_ready = 1'b0; dec_illegal = 1'b1; dec_halt = 1'b1; pc = 16'h0077;
    tick("il_decode",     3'd2, 0,0,0,0,0,0, 16'h0000);
    dec_illegal = 1'b0; dec_halt = 1'b0; pc = 16'h1234; start = 1'b1;
    tick("il_fault0",     3'd7, 0,0,0,0,0,0, 16'h0077);
    tick("il_fault1",     3'd7, 0,0,0,0,0,0, 16'h0077);
    start = 1'b0;

    // Fetch timeout: 4 FETCH cycles without ready, then sticky FAULT.
    rst_n = 1'b0;
    tick("to_fault_rst",  3'd7, 0,0,0,0,0,0, 16'h0077);
    rst_n = 1'b1; start = 1'b1; pc = 16'h0010;
    tick("to_start",      3'd0, 0,0,0,0,0,0, 16'h0000);
    start = 1'b0;
    for (int i = 0; i < 4; i++)
      tick($sformatf("to_fetch%0d", i), 3'd1, 1,0,0,0,0,0, 16'h0000);
    start = 1'b1; pc = 16'h00ff; imem_ready = 1'b1;
    tick("to_fault0",     3'd7, 0,0,0,0,0,0, 16'h0010);
    tick("to_fault1",     3'd7, 0,0,0,0,0,0, 16'h0010);
    start = 1'b0; imem_ready = 1'b0;

    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL drain: actual %0d records left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
